fetch_buffer: RTL

Dual-issue instruction fetch buffer sitting between the instruction cache and the two decode/execute datapaths. Accepts aligned pairs of 32-bit instructions (with their PCs) from the cache, holds them in a circular queue, and presents the two oldest instructions to the issue stage every cycle. The issue stage returns how many it actually took (0, 1 or 2), derived from its freeze1/freeze2 decisions. A flush input discards all buffered work on a control-flow redirect.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_buffer_mem.sv | 38 +++
 rtl/fetch_buffer.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the dual-issue fetch buffer.
package fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] ins;
  } fetch_entry_t;

  // The issue stage can take at most two per cycle, so the encoding 3 is treated as 2.
  function automatic logic [1:0] clamp_consume(input logic [1:0] c);
    return (c == 2'd3) ? 2'd2 : c;
  endfunction

endpackage

// File: rtl/fetch_buffer_mem.sv
// Entry storage for fetch_buffer: two write ports (tail, tail+1) and two async read ports (head, head+1).
// Writes land at the rising edge. Reads are combinational from the stored array.
module fetch_buffer_mem
  import fetch_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     we0,
  input  logic [$clog2(DEPTH)-1:0] waddr0,
  input  fetch_entry_t             wdat0,
  input  logic                     we1,
  input  logic [$clog2(DEPTH)-1:0] waddr1,
  input  fetch_entry_t             wdat1,
  input  logic [$clog2(DEPTH)-1:0] raddr0,
  input  logic [$clog2(DEPTH)-1:0] raddr1,
  output fetch_entry_t             rdat0,
  output fetch_entry_t             rdat1
);

  fetch_entry_t mem_q [DEPTH];
  fetch_entry_t mem_d [DEPTH];

  // The two write addresses are always distinct, so port order does not matter.
  always_comb begin
    mem_d = mem_q;
    if (we0) mem_d[waddr0] = wdat0;
    if (we1) mem_d[waddr1] = wdat1;
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rdat0 = mem_q[raddr0];
  assign rdat1 = mem_q[raddr1];

endmodule

// File: rtl/fetch_buffer.sv
// Dual-issue fetch queue: pairs in at tail, two oldest out combinationally; 1-cycle fill-to-issue,
// 0-cycle when empty with FETCH_BUFFER_BYPASS_EN. fill_ready drops once fewer than two slots remain.
module fetch_buffer #(
  parameter int DEPTH = 8,
  parameter int XLEN  = 32
) (
  input  logic                     hz100,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     fill_valid,
  output logic                     fill_ready,
  input  logic [XLEN-1:0]          fill_pc,
  input  logic [XLEN-1:0]          fill_ins0,
  input  logic [XLEN-1:0]          fill_ins1,
  output logic                     issue_valid0,
  output logic                     issue_valid1,
  output logic [XLEN-1:0]          instruction0,
  output logic [XLEN-1:0]          instruction1,
  output logic [XLEN-1:0]          pc0,
  output logic [XLEN-1:0]          pc1,
  input  logic [1:0]               consume,
  output logic [$clog2(DEPTH):0]   count
);

  import fetch_pkg::*;

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FILL_MAX = CW'(DEPTH - 2);

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [1:0]    cons_sat;
  logic [CW-1:0] avail;
  logic [CW-1:0] cons_eff;
  logic          fill_fire;
  logic          bypass;
  logic          we0, we1;
  fetch_entry_t  wdat0, wdat1;
  fetch_entry_t  rdat0, rdat1;
  logic          vld0, vld1;

  // Credit is judged on current occupancy only; a same-cycle consume does not help.
  assign fill_ready = reset && (cnt_q <= FILL_MAX);
  assign fill_fire  = fill_valid && fill_ready;

`ifdef FETCH_BUFFER_BYPASS_EN
  assign bypass = reset && fill_valid && (cnt_q == '0);
`else
  assign bypass = 1'b0;
`endif

  always_comb begin
    cons_sat = clamp_consume(consume);
    avail    = bypass ? CW'(2) : cnt_q;
    cons_eff = (CW'(cons_sat) > avail) ? avail : CW'(cons_sat);
    we0      = 1'b0;
    we1      = 1'b0;
    wdat0    = '{pc: fill_pc, ins: fill_ins0};
    wdat1    = '{pc: fill_pc + XLEN'(4), ins: fill_ins1};
    head_d   = head_q;
    tail_d   = tail_q;
    cnt_d    = cnt_q;
    if (bypass) begin
      // Empty buffer, so head == tail: only what issue did not take gets stored.
      case (cons_eff[1:0])
        2'd0: begin
          we0    = 1'b1;
          we1    = 1'b1;
          tail_d = tail_q + PW'(2);
          cnt_d  = CW'(2);
        end
        2'd1: begin
          we0    = 1'b1;
          wdat0  = wdat1;
          tail_d = tail_q + PW'(1);
          cnt_d  = CW'(1);
        end
        default: ;
      endcase
    end else begin
      we0    = fill_fire;
      we1    = fill_fire;
      head_d = head_q + PW'(cons_eff);
      tail_d = tail_q + (fill_fire ? PW'(2) : PW'(0));
      cnt_d  = cnt_q + (fill_fire ? CW'(2) : CW'(0)) - cons_eff;
    end
    if (flush) begin
      we0    = 1'b0;
      we1    = 1'b0;
      head_d = '0;
      tail_d = '0;
      cnt_d  = '0;
    end
  end

  always_ff @(posedge hz100) begin
    if (!reset) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  fetch_buffer_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk    (hz100),
    .we0    (we0 && reset),
    .waddr0 (tail_q),
    .wdat0  (wdat0),
    .we1    (we1 && reset),
    .waddr1 (tail_q + PW'(1)),
    .wdat1  (wdat1),
    .raddr0 (head_q),
    .raddr1 (head_q + PW'(1)),
    .rdat0  (rdat0),
    .rdat1  (rdat1)
  );

  always_comb begin
    vld0         = reset && (cnt_q != '0);
    vld1         = reset && (cnt_q >= CW'(2));
    issue_valid0 = vld0;
    issue_valid1 = vld1;
    instruction0 = NOP_INSTR;
    instruction1 = NOP_INSTR;
    pc0          = '0;
    pc1          = '0;
    if (bypass) begin
      issue_valid0 = 1'b1;
      issue_valid1 = 1'b1;
      instruction0 = fill_ins0;
      instruction1 = fill_ins1;
      pc0          = fill_pc;
      pc1          = fill_pc + XLEN'(4);
    end else begin
      if (vld0) begin
        instruction0 = rdat0.ins;
        pc0          = rdat0.pc;
      end
      if (vld1) begin
        instruction1 = rdat1.ins;
        pc1          = rdat1.pc;
      end
    end
  end

  assign count = cnt_q;

endmodule
